// File: rtl/trafclass_stats.sv
// Per-class frame statistics: saturating live counters, snapshot into shadow registers, 1-cycle read port.
// Optional 48-bit per-class byte counters are compiled in with `define TRAFCLASS_STATS_BYTES_EN.
module trafclass_stats #(
  parameter int unsigned CLASS_NUM = 16,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned ADDR_W    = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clken_i,
  input  logic                 class_valid_i,
  input  logic [CLASS_NUM-1:0] class_flags_i,
  input  logic                 crc_err_i,
  input  logic [15:0]          frm_len_i,
  input  logic                 snapshot_i,
  output logic                 snapshot_done_o,
  input  logic                 rd_en_i,
  input  logic [ADDR_W-1:0]    rd_addr_i,
  output logic [31:0]          rd_data_o,
  output logic                 rd_valid_o
);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [47:0]      byt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

  logic accept;
  cnt_t live_tot, live_crc, shd_tot, shd_crc;
  cnt_t nxt_tot, nxt_crc;
  cnt_t live_cls [CLASS_NUM];
  cnt_t shd_cls  [CLASS_NUM];
  cnt_t nxt_cls  [CLASS_NUM];
  logic [31:0] rd_word;

  assign accept = class_valid_i & clken_i;

`ifdef TRAFCLASS_STATS_BYTES_EN
  function automatic byt_t sat_add(input byt_t v, input logic [15:0] len);
    logic [48:0] sum;
    sum = {1'b0, v} + 49'(len);
    return sum[48] ? '1 : sum[47:0];
  endfunction

  byt_t live_byt [CLASS_NUM];
  byt_t shd_byt  [CLASS_NUM];
  byt_t nxt_byt  [CLASS_NUM];
`else
  logic unused_frm_len;
  assign unused_frm_len = ^frm_len_i;
`endif

  // A snapshot clears the base first, so an event in the same cycle lands in the new period.
  always_comb begin
    nxt_tot = snapshot_i ? '0 : live_tot;
    nxt_crc = snapshot_i ? '0 : live_crc;
    for (int unsigned i = 0; i < CLASS_NUM; i++) begin
      nxt_cls[i] = snapshot_i ? '0 : live_cls[i];
`ifdef TRAFCLASS_STATS_BYTES_EN
      nxt_byt[i] = snapshot_i ? '0 : live_byt[i];
`endif
    end
    if (accept) begin
      nxt_tot = sat_inc(nxt_tot);
      if (crc_err_i) begin
        nxt_crc = sat_inc(nxt_crc);
      end else begin
        for (int unsigned i = 0; i < CLASS_NUM; i++) begin
          if (class_flags_i[i]) begin
            nxt_cls[i] = sat_inc(nxt_cls[i]);
`ifdef TRAFCLASS_STATS_BYTES_EN
            nxt_byt[i] = sat_add(nxt_byt[i], frm_len_i);
`endif
          end
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (32'(rd_addr_i) == 0) rd_word = 32'(shd_tot);
    if (32'(rd_addr_i) == 1) rd_word = 32'(shd_crc);
    for (int unsigned i = 0; i < CLASS_NUM; i++) begin
      if (32'(rd_addr_i) == i + 2) rd_word = 32'(shd_cls[i]);
`ifdef TRAFCLASS_STATS_BYTES_EN
      if (32'(rd_addr_i) == CLASS_NUM + 2 + i)     rd_word = shd_byt[i][31:0];
      if (32'(rd_addr_i) == 2 * CLASS_NUM + 2 + i) rd_word = {16'h0000, shd_byt[i][47:32]};
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      live_tot        <= '0;
      live_crc        <= '0;
      shd_tot         <= '0;
      shd_crc         <= '0;
      live_cls        <= '{default: '0};
      shd_cls         <= '{default: '0};
`ifdef TRAFCLASS_STATS_BYTES_EN
      live_byt        <= '{default: '0};
      shd_byt         <= '{default: '0};
`endif
      snapshot_done_o <= 1'b0;
      rd_valid_o      <= 1'b0;
      rd_data_o       <= '0;
    end else begin
      live_tot <= nxt_tot;
      live_crc <= nxt_crc;
      live_cls <= nxt_cls;
`ifdef TRAFCLASS_STATS_BYTES_EN
      live_byt <= nxt_byt;
`endif
      if (snapshot_i) begin
        shd_tot <= live_tot;
        shd_crc <= live_crc;
        shd_cls <= live_cls;
`ifdef TRAFCLASS_STATS_BYTES_EN
        shd_byt <= live_byt;
`endif
      end
      snapshot_done_o <= snapshot_i;
      rd_valid_o      <= rd_en_i;
      if (rd_en_i) rd_data_o <= rd_word;
    end
  end

endmodule

// File: tb/tb_trafclass_stats.sv
// Self-checking bench for trafclass_stats: directed table, hand sequences, randomized run against a reference model.
module tb_trafclass_stats;

  localparam int NC = 16;
  localparam longint MAXC = (longint'(1) << 32) - 1;
  localparam longint MAXB = (longint'(1) << 48) - 1;

  logic        clk = 1'b0;
  logic        rst_n, clken, valid, crc, snapshot, rd_en;
  logic [15:0] flags, len;
  logic [6:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid, snapshot_done;

  // second instance with 16-bit counters for the saturation check
  logic        v2, snap2, rd_en2;
  logic [15:0] flags2;
  logic [6:0]  addr2;
  logic [31:0] data2;
  logic        valid2, done2;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  longint m_tot, m_crc, s_tot, s_crc, m_prev_rd;
  longint m_cls [NC];
  longint s_cls [NC];
  longint m_byt [NC];
  longint s_byt [NC];

  always #5 clk = ~clk;

  trafclass_stats #(.CLASS_NUM(NC), .CNT_W(32), .ADDR_W(7)) dut (
    .clk_i(clk), .rst_i(rst_n), .clken_i(clken), .class_valid_i(valid),
    .class_flags_i(flags), .crc_err_i(crc), .frm_len_i(len),
    .snapshot_i(snapshot), .snapshot_done_o(snapshot_done),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid)
  );

  trafclass_stats #(.CLASS_NUM(NC), .CNT_W(16), .ADDR_W(7)) dut_sat (
    .clk_i(clk), .rst_i(rst_n), .clken_i(1'b1), .class_valid_i(v2),
    .class_flags_i(flags2), .crc_err_i(1'b0), .frm_len_i(16'd0),
    .snapshot_i(snap2), .snapshot_done_o(done2),
    .rd_en_i(rd_en2), .rd_addr_i(addr2), .rd_data_o(data2), .rd_valid_o(valid2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic longint model_read(input int a);
    if (a == 0) return s_tot;
    if (a == 1) return s_crc;
    if (a >= 2 && a < NC + 2) return s_cls[a - 2];
`ifdef TRAFCLASS_STATS_BYTES_EN
    if (a >= NC + 2 && a < 2 * NC + 2) return s_byt[a - NC - 2] % (longint'(1) << 32);
    if (a >= 2 * NC + 2 && a < 3 * NC + 2) return s_byt[a - 2 * NC - 2] / (longint'(1) << 32);
`endif
    return 0;
  endfunction

  function automatic void model_update();
    if (!rst_n) begin
      m_tot = 0; m_crc = 0; s_tot = 0; s_crc = 0;
      m_cls = '{default: 0}; s_cls = '{default: 0};
      m_byt = '{default: 0}; s_byt = '{default: 0};
      return;
    end
    if (snapshot) begin
      s_tot = m_tot; s_crc = m_crc; s_cls = m_cls; s_byt = m_byt;
      m_tot = 0; m_crc = 0;
      m_cls = '{default: 0}; m_byt = '{default: 0};
    end
    if (valid && clken) begin
      m_tot = sat(m_tot + 1, MAXC);
      if (crc) m_crc = sat(m_crc + 1, MAXC);
      else
        for (int i = 0; i < NC; i++)
          if (flags[i]) begin
            m_cls[i] = sat(m_cls[i] + 1, MAXC);
            m_byt[i] = sat(m_byt[i] + longint'(len), MAXB);
          end
    end
  endfunction

  // One clock with current inputs; model predicts the registered outputs seen after the edge.
  task automatic step();
    longint e_data;
    bit e_valid, e_done;
    if (!rst_n) begin
      e_valid = 0; e_done = 0; e_data = 0;
    end else begin
      e_valid = rd_en; e_done = snapshot;
      e_data = rd_en ? model_read(int'(rd_addr)) : m_prev_rd;
    end
    model_update();
    m_prev_rd = e_data;
    @(posedge clk); #1;
    if (snapshot_done) done_cnt++;
    chk("rd_valid", 64'(rd_valid), 64'(e_valid));
    chk("rd_data", 64'(rd_data), 64'(e_data));
    chk("snapshot_done", 64'(snapshot_done), 64'(e_done));
  endtask

  task automatic events(input int n, input bit ce, input logic [15:0] f, input bit ce_crc, input logic [15:0] l);
    valid = 1; clken = ce; flags = f; crc = ce_crc; len = l;
    repeat (n) step();
    valid = 0; clken = 1; flags = '0; crc = 0; len = '0;
  endtask

  task automatic snap();
    snapshot = 1; step(); snapshot = 0;
  endtask

  task automatic rd(input int a);
    rd_en = 1; rd_addr = 7'(a); step(); rd_en = 0;
  endtask

  typedef struct {
    int          n;
    bit          ce;
    logic [15:0] flags;
    bit          crc;
    longint      e_tot;
    longint      e_crc;
    longint      e_hit;
  } vec_t;

  vec_t tbl [4];

  initial begin
    tbl[0] = '{n: 3, ce: 1, flags: 16'h0005, crc: 0, e_tot: 3, e_crc: 0, e_hit: 3};
    tbl[1] = '{n: 1, ce: 1, flags: 16'hFFFF, crc: 1, e_tot: 1, e_crc: 1, e_hit: 0};
    tbl[2] = '{n: 1, ce: 0, flags: 16'hFFFF, crc: 0, e_tot: 0, e_crc: 0, e_hit: 0};
    tbl[3] = '{n: 5, ce: 1, flags: 16'h8001, crc: 0, e_tot: 5, e_crc: 0, e_hit: 5};

    rst_n = 0; clken = 1; valid = 0; crc = 0; snapshot = 0; rd_en = 0;
    flags = '0; len = '0; rd_addr = '0;
    v2 = 0; snap2 = 0; rd_en2 = 0; flags2 = '0; addr2 = '0;
    m_prev_rd = 0;
    step(); step();
    rst_n = 1;
    step();
    rd(0);
    chk("reset_total", 64'(rd_data), 64'd0);

    for (int t = 0; t < 4; t++) begin
      events(tbl[t].n, tbl[t].ce, tbl[t].flags, tbl[t].crc, 16'd64);
      done_cnt = 0;
      snap();
      step();
      chk($sformatf("tbl%0d_done_count", t), 64'(done_cnt), 64'd1);
      rd(0); chk($sformatf("tbl%0d_total", t), 64'(rd_data), 64'(tbl[t].e_tot));
      rd(1); chk($sformatf("tbl%0d_crc", t), 64'(rd_data), 64'(tbl[t].e_crc));
      for (int i = 0; i < NC; i++) begin
        rd(i + 2);
        chk($sformatf("tbl%0d_class%0d", t, i), 64'(rd_data),
            64'(tbl[t].flags[i] ? tbl[t].e_hit : 0));
      end
    end

    // event coincident with snapshot belongs to the new period
    events(2, 1, 16'h0001, 0, 16'd100);
    valid = 1; flags = 16'h0001; snapshot = 1;
    step();
    valid = 0; flags = '0; snapshot = 0;
    rd(2); chk("same_cycle_snap1", 64'(rd_data), 64'd2);
    snap();
    rd(2); chk("same_cycle_snap2", 64'(rd_data), 64'd1);

    // byte counters
    events(2, 1, 16'h0001, 0, 16'd1518);
    snap();
    rd(NC + 2);
`ifdef TRAFCLASS_STATS_BYTES_EN
    chk("bytes_lo_cls0", 64'(rd_data), 64'd3036);
`else
    chk("bytes_lo_cls0", 64'(rd_data), 64'd0);
`endif
    rd(2 * NC + 2); chk("bytes_hi_cls0", 64'(rd_data), 64'd0);
    rd(100); chk("unmapped", 64'(rd_data), 64'd0);

    // read in the snapshot cycle returns pre-snapshot shadow; back-to-back snapshots
    events(4, 1, 16'h0002, 0, 16'd10);
    rd_en = 1; rd_addr = 7'd0; snapshot = 1; step();
    chk("read_at_snap_pre", 64'(rd_data), 64'd2);
    rd_en = 0; step(); snapshot = 0;
    rd(0); chk("back_to_back_snap", 64'(rd_data), 64'd0);

    // reset mid-operation drops pending pulses and clears counters
    events(3, 1, 16'h00FF, 0, 16'd20);
    rd_en = 1; snapshot = 1; rst_n = 0; step();
    rd_en = 0; snapshot = 0; rst_n = 1;
    snap();
    rd(0); chk("midreset_total", 64'(rd_data), 64'd0);
    rd(3); chk("midreset_class1", 64'(rd_data), 64'd0);

    // randomized run against the model
    for (int k = 0; k < 600; k++) begin
      valid    = ($urandom_range(0, 1) == 1);
      clken    = ($urandom_range(0, 4) != 0);
      crc      = ($urandom_range(0, 4) == 0);
      flags    = 16'($urandom);
      len      = 16'($urandom);
      snapshot = ($urandom_range(0, 9) == 0);
      rd_en    = ($urandom_range(0, 1) == 1);
      rd_addr  = 7'($urandom_range(0, 60));
      step();
    end
    valid = 0; snapshot = 0; rd_en = 0;

    // saturation on the 16-bit instance: 65537 events from zero
    v2 = 1; flags2 = 16'h0001;
    repeat (65537) @(posedge clk);
    #1; v2 = 0; snap2 = 1;
    @(posedge clk); #1;
    snap2 = 0;
    chk("sat_done", 64'(done2), 64'd1);
    rd_en2 = 1; addr2 = 7'd2;
    @(posedge clk); #1;
    chk("sat_valid", 64'(valid2), 64'd1);
    chk("sat_class0", 64'(data2), 64'hFFFF);
    addr2 = 7'd0;
    @(posedge clk); #1;
    chk("sat_total", 64'(data2), 64'hFFFF);
    addr2 = 7'd1;
    @(posedge clk); #1;
    chk("sat_crc", 64'(data2), 64'd0);
    rd_en2 = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trafclass_stats.md
Name: trafclass_stats

Overview:
- Per-class frame statistics stage placed directly downstream of the traffic classifier.
- Takes the classifier's per-frame result flags, qualified by a one-cycle end-of-frame strobe, and accumulates saturating per-class frame counters plus total and CRC-error counters.
- Software takes a coherent snapshot of all counters with a single pulse, which also clears the live counters. The shadowed values are then read over a simple one-cycle-latency read port.

Parameters:
- CLASS_NUM, 16: number of class flag inputs counted; 1..32.
- CNT_W, 32: width of each frame counter; 16..32.
- ADDR_W, 7: read address width; must satisfy 2^ADDR_W >= 3*CLASS_NUM+2.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- clken_i  in  1  clock enable; gates event counting only.
- class_valid_i  in  1  one-cycle strobe; class_flags_i, crc_err_i and frm_len_i are valid this cycle.
- class_flags_i  in  CLASS_NUM  classifier result flags (bit i = class i hit).
- crc_err_i  in  1  frame had CRC error.
- frm_len_i  in  16  frame length in bytes.
- snapshot_i  in  1  pulse: copy live counters to shadow, clear live.
- snapshot_done_o  out  1  one-cycle pulse, one cycle after snapshot_i accepted.
- rd_en_i  in  1  read request.
- rd_addr_i  in  ADDR_W  shadow register address.
- rd_data_o  out  32  read data, zero-extended.
- rd_valid_o  out  1  rd_data_o valid.

Behaviour:
- Reset (rst_i low at clock edge): all live and shadow counters = 0; snapshot_done_o = 0; rd_valid_o = 0; rd_data_o = 0.
- Event accepted when class_valid_i & clken_i.
  - Total counter +1 for every accepted event.
  - If crc_err_i = 1: CRC-error counter +1. No class counter changes, even if flags are set.
  - If crc_err_i = 0: class counter i +1 for every set bit i. Several bits may increment in the same cycle.
- Saturation: a counter at all-ones stays at all-ones; there is no wrap.
- Live counters update one cycle after acceptance.
- Snapshot (snapshot_i = 1, independent of clken_i):
  - Shadow <= live counter values at that edge, excluding any event accepted in the same cycle.
  - Live counters are cleared, except that an event accepted in the same cycle loads the live counters with its increment, i.e. it is counted in the new period.
  - snapshot_done_o pulses the next cycle.
  - Back-to-back snapshot pulses are each honoured.
- Read port: rd_en_i at cycle T gives rd_valid_o = 1 and rd_data_o at T+1. rd_valid_o is 0 otherwise. rd_data_o holds its last value while rd_valid_o = 0.
- Address map (shadow only):
  - 0: total.
  - 1: CRC error.
  - 2..CLASS_NUM+1: class 0..CLASS_NUM-1.
  - Byte-counter words: see Optional Feature.
  - Unmapped addresses read 0.
- A read in the same cycle as a snapshot returns the pre-snapshot shadow value.
- Reset mid-operation: counters cleared; any pending rd_valid_o or snapshot_done_o is dropped.
- frm_len_i is ignored unless the optional feature is compiled in.

Optional Feature:
- Macro: TRAFCLASS_STATS_BYTES_EN.
- Defined:
  - Adds a 48-bit saturating byte counter per class, incremented by frm_len_i under the same rules as the class frame counters (CRC-error frames excluded).
  - Byte counters are snapshotted and cleared together with the frame counters.
  - Read map: addresses CLASS_NUM+2..2*CLASS_NUM+1 return bits [31:0]; 2*CLASS_NUM+2..3*CLASS_NUM+1 return bits [47:32] zero-extended.
- Undefined: no byte counters; those addresses read 0; frm_len_i is unused.

Test Plan:
- Reset, then 3 accepted events with flags = 16'h0005 and crc_err = 0, then snapshot, then read addresses 0, 2, 3, 4 -> 3, 3, 0, 3; snapshot_done_o pulses exactly once.
- Accepted event with flags = 16'hFFFF and crc_err = 1, snapshot -> addr 0 = 1, addr 1 = 1, all class counters = 0.
- Event with class_valid = 1 but clken_i = 0 -> no counter changes; snapshot -> all reads 0.
- Event (flags = 16'h0001) in the same cycle as snapshot, after 2 earlier flag-0 events -> first snapshot addr 2 = 2; second snapshot addr 2 = 1.
- Force live class-0 counter to 32'hFFFF_FFFE, apply 3 events, snapshot -> addr 2 = 32'hFFFF_FFFF.
- With TRAFCLASS_STATS_BYTES_EN defined: 2 frames of 1518 bytes, flag bit 0, snapshot -> addr 18 = 3036, addr 34 = 0. Without the macro -> addr 18 = 0.
